// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - shared TL-UL opcodes, GPIO register offsets and responder FSM states
package tlul_pkg;

    // Channel A request opcodes
    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    // Channel D response opcodes
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // GPIO register offsets within the 4 KB window
    localparam logic [11:0] OFF_DATA_IN     = 12'h000;
    localparam logic [11:0] OFF_DATA_OUT    = 12'h004;
    localparam logic [11:0] OFF_DIR         = 12'h008;
    localparam logic [11:0] OFF_INTR_STATE  = 12'h00C;
    localparam logic [11:0] OFF_INTR_ENABLE = 12'h010;

    // One transaction outstanding: either waiting for a request or presenting a response
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } tl_state_e;

    // Expand a 4-bit byte-lane mask into a 32-bit bit mask
    function automatic logic [31:0] mask_to_bits(input logic [3:0] m);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            b[i*8 +: 8] = {8{m[i]}};
        end
        return b;
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - two-flop pad synchronizer with rising-edge detect
module gpio_in_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain followed by the previous-value register for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= gpio_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/tlul_gpio_slave.sv
// rtl/tlul_gpio_slave.sv - TL-UL slave endpoint for a 32-bit GPIO register block
module tlul_gpio_slave
    import tlul_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SIZE_WIDTH = 3,
    parameter int                    SRC_WIDTH  = 2,
    parameter int                    SINK_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] BASE_MASK  = 32'hFFFF_F000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [2:0]              a_opcode,
    input  logic [2:0]              a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [DATA_WIDTH/8-1:0] a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [2:0]              d_opcode,
    output logic [2:0]              d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error,
    input  logic [31:0]             gpio_in,
    output logic [31:0]             gpio_out,
    output logic [31:0]             gpio_oe,
    output logic                    intr
);

    tl_state_e state_q, state_d;

    logic [31:0] data_out_q, data_out_d;
    logic [31:0] dir_q, dir_d;
    logic [31:0] intr_state_q, intr_state_d;
    logic [31:0] intr_enable_q, intr_enable_d;

    logic [2:0]            rsp_opcode_q;
    logic [SIZE_WIDTH-1:0] rsp_size_q;
    logic [SRC_WIDTH-1:0]  rsp_source_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_error_q;

    logic [31:0]           data_in;
    logic [31:0]           rise;
    logic                  accept;
    logic [11:0]           offset;
    logic                  is_get;
    logic                  is_put;
    logic                  off_hit;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] rdata;
    logic [31:0]           bit_mask;
    logic [31:0]           wr_bits;
    logic [31:0]           w1c;
    logic                  wr_en;
    logic                  unused_a_param;

    // a_param carries no meaning for this responder
    assign unused_a_param = ^a_param;

    gpio_in_sync #(
        .WIDTH (32)
    ) u_gpio_in_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .gpio_i (gpio_in),
        .sync_o (data_in),
        .rise_o (rise)
    );

    // Handshake FSM: accept one request in IDLE, present its response in RESP
    always_comb begin
        state_d = state_q;
        a_ready = 1'b0;
        d_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                a_ready = reset_n;
                if (a_valid && reset_n) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                d_valid = 1'b1;
                if (d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = a_valid & a_ready;

    // Request decode: legality checks and read-data mux on the current register values
    always_comb begin
        offset  = a_address[11:0];
        is_get  = (a_opcode == GET);
        is_put  = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
        off_hit = 1'b1;
        rdata   = '0;
        case (offset)
            OFF_DATA_IN:     rdata = data_in;
            OFF_DATA_OUT:    rdata = data_out_q;
            OFF_DIR:         rdata = dir_q;
            OFF_INTR_STATE:  rdata = intr_state_q;
            OFF_INTR_ENABLE: rdata = intr_enable_q;
            default:         off_hit = 1'b0;
        endcase
        req_err = !(is_get || is_put)
               || (a_size > SIZE_WIDTH'(2))
               || (a_address[1:0] != 2'b00)
               || ((a_address & BASE_MASK) != BASE_ADDR)
               || !off_hit
               || (is_put && (offset == OFF_DATA_IN));
    end

    // Register next-state: byte-lane writes, W1C on INTR_STATE, hardware rise wins over clear
    always_comb begin
        bit_mask      = mask_to_bits(a_mask);
        wr_bits       = a_data & bit_mask;
        wr_en         = accept && is_put && !req_err;
        data_out_d    = data_out_q;
        dir_d         = dir_q;
        intr_enable_d = intr_enable_q;
        w1c           = '0;
        if (wr_en) begin
            case (offset)
                OFF_DATA_OUT:    data_out_d    = (data_out_q & ~bit_mask) | wr_bits;
                OFF_DIR:         dir_d         = (dir_q & ~bit_mask) | wr_bits;
                OFF_INTR_ENABLE: intr_enable_d = (intr_enable_q & ~bit_mask) | wr_bits;
                OFF_INTR_STATE:  w1c           = wr_bits;
                default:         ;
            endcase
        end
        intr_state_d = (intr_state_q & ~w1c) | rise;
    end

    // State, register file and response latch; response fields only load on accept
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            data_out_q    <= '0;
            dir_q         <= '0;
            intr_state_q  <= '0;
            intr_enable_q <= '0;
            rsp_opcode_q  <= '0;
            rsp_size_q    <= '0;
            rsp_source_q  <= '0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_out_q    <= data_out_d;
            dir_q         <= dir_d;
            intr_state_q  <= intr_state_d;
            intr_enable_q <= intr_enable_d;
            if (accept) begin
                rsp_opcode_q <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
                rsp_size_q   <= a_size;
                rsp_source_q <= a_source;
                rsp_data_q   <= (is_get && !req_err) ? rdata : '0;
                rsp_error_q  <= req_err;
            end
        end
    end

    assign d_opcode = rsp_opcode_q;
    assign d_param  = '0;
    assign d_size   = rsp_size_q;
    assign d_source = rsp_source_q;
    assign d_sink   = '0;
    assign d_data   = rsp_data_q;
    assign d_error  = rsp_error_q;

    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign intr     = |(intr_state_q & intr_enable_q);

endmodule

// File: tb/tb_tlul_gpio_slave.sv
// tb/tb_tlul_gpio_slave.sv - self-checking bench for tlul_gpio_slave
module tb_tlul_gpio_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic [1:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        intr;

    int checks   = 0;
    int failures = 0;

    // response captured one cycle after accept
    logic        r_valid;
    logic [2:0]  r_opcode;
    logic [2:0]  r_param;
    logic [2:0]  r_size;
    logic [1:0]  r_source;
    logic [0:0]  r_sink;
    logic [31:0] r_data;
    logic        r_error;
    logic [31:0] r_gpio_out;
    logic [31:0] r_gpio_oe;
    logic        r_intr;

    // reference model state
    logic [31:0] m_out, m_dir, m_ist, m_ien, m_gpio;

    always #5 clk = ~clk;

    tlul_gpio_slave dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_data    (d_data),
        .d_error   (d_error),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe   (gpio_oe),
        .intr      (intr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // one full transaction with d_ready held high; fields captured at N+1
    task automatic txn(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [3:0] msk, input logic [31:0] dat, input logic [1:0] src);
        int cnt;
        @(negedge clk);
        a_opcode  = op;
        a_size    = sz;
        a_address = addr;
        a_mask    = msk;
        a_data    = dat;
        a_source  = src;
        a_param   = 3'($urandom_range(0, 7));
        a_valid   = 1'b1;
        d_ready   = 1'b1;
        cnt = 0;
        while (!a_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!a_ready) check("accept_timeout", 32'(a_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid    = 1'b0;
        r_valid    = d_valid;
        r_opcode   = d_opcode;
        r_param    = d_param;
        r_size     = d_size;
        r_source   = d_source;
        r_sink     = d_sink;
        r_data     = d_data;
        r_error    = d_error;
        r_gpio_out = gpio_out;
        r_gpio_oe  = gpio_oe;
        r_intr     = intr;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] b;
        b = 32'h0;
        if (m[0]) b = b | 32'h0000_00FF;
        if (m[1]) b = b | 32'h0000_FF00;
        if (m[2]) b = b | 32'h00FF_0000;
        if (m[3]) b = b | 32'hFF00_0000;
        return b;
    endfunction

    // watchdog: the run must never hang
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cnt;
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [3:0]  msk;
        logic [31:0] dat;
        logic [1:0]  src;
        logic [11:0] off;
        logic [31:0] newg;
        logic [31:0] rd;
        logic [31:0] bm;
        logic        e_get, e_put, e_err;
        logic [11:0] offs [8];

        offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h800, 12'hFFC};

        reset_n = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
        a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; gpio_in = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_d_data", d_data, 32'd0);
        check("rst_d_opcode", 32'(d_opcode), 32'd0);
        check("rst_gpio_out", gpio_out, 32'd0);
        check("rst_gpio_oe", gpio_oe, 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_a_ready", 32'(a_ready), 32'd1);

        // PutFullData to DATA_OUT
        txn(3'd0, 3'd2, 32'h04, 4'hF, 32'hA5A5_0F0F, 2'd2);
        check("pf_valid", 32'(r_valid), 32'd1);
        check("pf_opcode", 32'(r_opcode), 32'd0);
        check("pf_error", 32'(r_error), 32'd0);
        check("pf_source", 32'(r_source), 32'd2);
        check("pf_gpio_out", r_gpio_out, 32'hA5A5_0F0F);
        check("pf_after_a_ready", 32'(a_ready), 32'd1);
        check("pf_after_d_valid", 32'(d_valid), 32'd0);

        // PutPartialData onto all-ones
        txn(3'd0, 3'd2, 32'h04, 4'hF, 32'hFFFF_FFFF, 2'd0);
        txn(3'd1, 3'd2, 32'h04, 4'h2, 32'h0000_3C00, 2'd1);
        check("pp_opcode", 32'(r_opcode), 32'd0);
        txn(3'd4, 3'd2, 32'h04, 4'hF, 32'h0, 2'd3);
        check("pp_get_opcode", 32'(r_opcode), 32'd1);
        check("pp_get_data", r_data, 32'hFFFF_3CFF);
        check("pp_get_source", 32'(r_source), 32'd3);

        // rising-edge interrupt
        txn(3'd0, 3'd2, 32'h10, 4'hF, 32'h20, 2'd0);
        @(negedge clk);
        gpio_in = 32'h20;
        cnt = 0;
        while (!intr && cnt < 3) begin
            @(negedge clk);
            cnt++;
        end
        check("intr_rise", 32'(intr), 32'd1);
        txn(3'd0, 3'd2, 32'h0C, 4'hF, 32'h20, 2'd0);
        check("intr_w1c_n1", 32'(r_intr), 32'd0);
        check("intr_w1c_after", 32'(intr), 32'd0);
        txn(3'd4, 3'd2, 32'h00, 4'hF, 32'h0, 2'd0);
        check("data_in_get", r_data, 32'h20);

        // rise lands on the same edge as the W1C
        gpio_in = 32'h0;
        repeat (4) @(negedge clk);
        gpio_in = 32'h20;
        @(negedge clk);
        txn(3'd0, 3'd2, 32'h0C, 4'hF, 32'h20, 2'd0);
        check("intr_set_wins", 32'(r_intr), 32'd1);
        txn(3'd4, 3'd2, 32'h0C, 4'hF, 32'h0, 2'd0);
        check("intr_state_kept", r_data, 32'h20);
        txn(3'd0, 3'd2, 32'h0C, 4'hF, 32'h20, 2'd0);
        check("intr_clear2", 32'(intr), 32'd0);

        // error responses
        txn(3'd4, 3'd2, 32'h14, 4'hF, 32'h0, 2'd1);
        check("err_off14", 32'(r_error), 32'd1);
        check("err_off14_data", r_data, 32'd0);
        check("err_off14_op", 32'(r_opcode), 32'd1);
        txn(3'd4, 3'd2, 32'h02, 4'hF, 32'h0, 2'd1);
        check("err_misalign", 32'(r_error), 32'd1);
        check("err_misalign_data", r_data, 32'd0);
        txn(3'd4, 3'd2, 32'h1000, 4'hF, 32'h0, 2'd1);
        check("err_base", 32'(r_error), 32'd1);
        check("err_base_data", r_data, 32'd0);
        txn(3'd2, 3'd2, 32'h04, 4'hF, 32'h1234_5678, 2'd1);
        check("err_op2", 32'(r_error), 32'd1);
        check("err_op2_opcode", 32'(r_opcode), 32'd0);
        check("err_op2_data", r_data, 32'd0);
        txn(3'd0, 3'd3, 32'h04, 4'hF, 32'h1234_5678, 2'd1);
        check("err_size3", 32'(r_error), 32'd1);
        txn(3'd0, 3'd2, 32'h00, 4'hF, 32'h1234_5678, 2'd1);
        check("err_wr_data_in", 32'(r_error), 32'd1);
        txn(3'd4, 3'd2, 32'h04, 4'hF, 32'h0, 2'd0);
        check("err_regs_unchanged", r_data, 32'hFFFF_3CFF);

        // backpressure: response held, second request waits
        @(negedge clk);
        a_opcode = 3'd4; a_size = 3'd2; a_address = 32'h04; a_mask = 4'hF;
        a_source = 2'd1; a_valid = 1'b1; d_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_address = 32'h08; a_source = 2'd2;
        for (int i = 0; i < 5; i++) begin
            check("bp_d_valid", 32'(d_valid), 32'd1);
            check("bp_a_ready", 32'(a_ready), 32'd0);
            check("bp_source", 32'(d_source), 32'd1);
            check("bp_data", d_data, 32'hFFFF_3CFF);
            check("bp_opcode", 32'(d_opcode), 32'd1);
            @(negedge clk);
        end
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_a_ready", 32'(a_ready), 32'd1);
        check("bp_release_d_valid", 32'(d_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check("bp_second_source", 32'(d_source), 32'd2);
        check("bp_second_data", d_data, 32'd0);
        @(posedge clk);
        @(negedge clk);

        // reset in the middle of a response
        gpio_in = 32'h0;
        repeat (4) @(negedge clk);
        txn(3'd0, 3'd2, 32'h08, 4'hF, 32'h0000_FFFF, 2'd0);
        check("dir_gpio_oe", r_gpio_oe, 32'h0000_FFFF);
        @(negedge clk);
        a_opcode = 3'd4; a_address = 32'h08; a_valid = 1'b1; d_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check("mid_resp_d_valid", 32'(d_valid), 32'd1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst2_d_valid", 32'(d_valid), 32'd0);
        check("rst2_gpio_oe", gpio_oe, 32'd0);
        check("rst2_gpio_out", gpio_out, 32'd0);
        check("rst2_intr", 32'(intr), 32'd0);
        check("rst2_d_data", d_data, 32'd0);
        check("rst2_a_ready", 32'(a_ready), 32'd0);
        reset_n = 1'b1;
        d_ready = 1'b1;
        @(negedge clk);
        check("rst2_post_a_ready", 32'(a_ready), 32'd1);

        // randomized traffic against the register-level model
        m_out = '0; m_dir = '0; m_ist = '0; m_ien = '0; m_gpio = '0;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                newg = $urandom;
                @(negedge clk);
                gpio_in = newg;
                m_ist = m_ist | (newg & ~m_gpio);
                m_gpio = newg;
                repeat (4) @(negedge clk);
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 3'd4;
                4, 5:       op = 3'd0;
                6, 7:       op = 3'd1;
                default: begin
                    case ($urandom_range(0, 4))
                        0:       op = 3'd2;
                        1:       op = 3'd3;
                        2:       op = 3'd5;
                        3:       op = 3'd6;
                        default: op = 3'd7;
                    endcase
                end
            endcase
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) off = offs[$urandom_range(0, 4)];
            else                           off = offs[$urandom_range(0, 7)];
            addr = {20'h0, off};
            if ($urandom_range(0, 9) == 0) addr = addr | ($urandom & 32'hFFFF_F000) | 32'h0000_1000;
            if ($urandom_range(0, 9) == 0) addr = addr | 32'($urandom_range(1, 3));
            msk = 4'($urandom_range(0, 15));
            dat = $urandom;
            src = 2'($urandom_range(0, 3));

            e_get = (op == 3'd4);
            e_put = (op == 3'd0) || (op == 3'd1);
            e_err = !(e_get || e_put) || (sz > 3'd2) || (addr[1:0] != 2'b00)
                 || (addr[31:12] != 20'h0)
                 || !(addr[11:0] == 12'h000 || addr[11:0] == 12'h004 || addr[11:0] == 12'h008
                      || addr[11:0] == 12'h00C || addr[11:0] == 12'h010)
                 || (e_put && addr[11:0] == 12'h000);
            case (addr[11:0])
                12'h000: rd = m_gpio;
                12'h004: rd = m_out;
                12'h008: rd = m_dir;
                12'h00C: rd = m_ist;
                12'h010: rd = m_ien;
                default: rd = 32'h0;
            endcase
            if (e_put && !e_err) begin
                bm = lanes(msk);
                case (addr[11:0])
                    12'h004: m_out = (m_out & ~bm) | (dat & bm);
                    12'h008: m_dir = (m_dir & ~bm) | (dat & bm);
                    12'h00C: m_ist = m_ist & ~(dat & bm);
                    12'h010: m_ien = (m_ien & ~bm) | (dat & bm);
                    default: ;
                endcase
            end

            txn(op, sz, addr, msk, dat, src);
            check("rnd_valid", 32'(r_valid), 32'd1);
            check("rnd_opcode", 32'(r_opcode), e_get ? 32'd1 : 32'd0);
            check("rnd_error", 32'(r_error), 32'(e_err));
            check("rnd_data", r_data, (e_get && !e_err) ? rd : 32'd0);
            check("rnd_source", 32'(r_source), 32'(src));
            check("rnd_size", 32'(r_size), 32'(sz));
            check("rnd_sink_param", {28'h0, r_sink, r_param}, 32'd0);
            check("rnd_gpio_out", r_gpio_out, m_out);
            check("rnd_gpio_oe", r_gpio_oe, m_dir);
            check("rnd_intr", 32'(r_intr), 32'(|(m_ist & m_ien)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
